// File: rtl/spi_stream_master.sv
`default_nettype none
// ============================================================================
//  Module      : spi_stream_master
//  Description : SPI master shifter with valid/ready word streaming, four SPI
//                modes, software-owned slave selects and a half-period divider.
//  Revision    : 1.0  initial release
// ============================================================================
module spi_stream_master #(
    parameter int NSS       = 2,
    parameter int WIDTH     = 8,
    parameter int DIVW      = 4,
    parameter int MSB_FIRST = 1
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             cfg_wr,
    input  logic [NSS-1:0]   cfg_ss,
    input  logic             cfg_cpol,
    input  logic             cfg_cpha,
    input  logic [DIVW-1:0]  cfg_div,
    input  logic             tx_valid,
    input  logic [WIDTH-1:0] tx_data,
    output logic             tx_ready,
    output logic             rx_valid,
    output logic [WIDTH-1:0] rx_data,
    output logic             busy,
    output logic             SCK,
    output logic             MOSI,
    input  logic [NSS-1:0]   MISO,
    output logic [NSS-1:0]   nSS
);

    localparam int                 c_cnt_w = $clog2(WIDTH + 1);
    localparam logic [c_cnt_w-1:0] c_bits  = c_cnt_w'(WIDTH);
    localparam logic [c_cnt_w-1:0] c_one   = c_cnt_w'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LEAD  = 2'd1,
        S_TRAIL = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t             r_state;
    logic [NSS-1:0]     r_ss;
    logic               r_cpol;
    logic               r_cpha;
    logic [DIVW-1:0]    r_div;
    logic [DIVW-1:0]    r_hdiv;
    logic [DIVW-1:0]    r_cnt;
    logic [c_cnt_w-1:0] r_bits;
    logic [WIDTH-1:0]   r_tx;
    logic [WIDTH-1:0]   r_rx;
    logic [WIDTH-1:0]   r_rx_data;
    logic               r_rx_valid;
    logic               r_busy;
    logic               r_tx_ready;
    logic               r_sck;
    logic               r_mosi;

    logic               w_cfg_take;
    logic               w_cpha_eff;
    logic [DIVW-1:0]    w_div_eff;
    logic               w_half;
    logic               w_last;
    logic               w_miso;
    logic               w_first_bit;
    logic [WIDTH-1:0]   w_load_shift;
    logic               w_out_bit;
    logic [WIDTH-1:0]   w_tx_shift;
    logic [WIDTH-1:0]   w_rx_next;

    // Config is only taken while no transfer is running; when it coincides
    // with an accept the new settings govern that very transfer.
    assign w_cfg_take = cfg_wr & ~r_busy;
    assign w_cpha_eff = w_cfg_take ? cfg_cpha : r_cpha;
    assign w_div_eff  = w_cfg_take ? cfg_div  : r_div;
    assign w_half     = (r_cnt == r_hdiv);
    assign w_last     = (r_bits == c_one);
    assign w_miso     = |(MISO & ~r_ss);

    generate
        if (MSB_FIRST != 0) begin : g_msb_first
            assign w_first_bit  = tx_data[WIDTH-1];
            assign w_load_shift = {tx_data[WIDTH-2:0], 1'b0};
            assign w_out_bit    = r_tx[WIDTH-1];
            assign w_tx_shift   = {r_tx[WIDTH-2:0], 1'b0};
            assign w_rx_next    = {r_rx[WIDTH-2:0], w_miso};
        end else begin : g_lsb_first
            assign w_first_bit  = tx_data[0];
            assign w_load_shift = {1'b0, tx_data[WIDTH-1:1]};
            assign w_out_bit    = r_tx[0];
            assign w_tx_shift   = {1'b0, r_tx[WIDTH-1:1]};
            assign w_rx_next    = {w_miso, r_rx[WIDTH-1:1]};
        end
    endgenerate

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state    <= S_IDLE;
            r_ss       <= '1;
            r_cpol     <= 1'b0;
            r_cpha     <= 1'b0;
            r_div      <= '0;
            r_hdiv     <= '0;
            r_cnt      <= '0;
            r_bits     <= '0;
            r_tx       <= '0;
            r_rx       <= '0;
            r_rx_data  <= '0;
            r_rx_valid <= 1'b0;
            r_busy     <= 1'b0;
            r_tx_ready <= 1'b1;
            r_sck      <= 1'b0;
            r_mosi     <= 1'b1;
        end else begin
            r_rx_valid <= 1'b0;
            if (w_cfg_take) begin
                r_ss   <= cfg_ss;
                r_cpol <= cfg_cpol;
                r_cpha <= cfg_cpha;
                r_div  <= cfg_div;
                r_sck  <= cfg_cpol;
            end
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (tx_valid) begin
                        r_state    <= S_LEAD;
                        r_busy     <= 1'b1;
                        r_tx_ready <= 1'b0;
                        r_hdiv     <= w_div_eff;
                        r_cnt      <= '0;
                        r_bits     <= c_bits;
                        r_rx       <= '0;
                        // cpha=0 presents the first bit before the first edge
                        if (w_cpha_eff) begin
                            r_tx <= tx_data;
                        end else begin
                            r_mosi <= w_first_bit;
                            r_tx   <= w_load_shift;
                        end
                    end else begin
                        r_state <= S_IDLE;
                        r_mosi  <= 1'b1;
                    end
                end
                S_LEAD: begin
                    if (w_half) begin
                        r_cnt   <= '0;
                        r_sck   <= ~r_cpol;
                        r_state <= S_TRAIL;
                        if (r_cpha) begin
                            r_mosi <= w_out_bit;
                            r_tx   <= w_tx_shift;
                        end else begin
                            r_rx <= w_rx_next;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_TRAIL: begin
                    if (w_half) begin
                        r_cnt  <= '0;
                        r_sck  <= r_cpol;
                        r_bits <= r_bits - 1'b1;
                        if (r_cpha) begin
                            r_rx <= w_rx_next;
                        end else if (!w_last) begin
                            r_mosi <= w_out_bit;
                            r_tx   <= w_tx_shift;
                        end
                        if (w_last) begin
                            // cpha=1 takes its final sample on this very edge
                            r_state    <= S_DONE;
                            r_rx_data  <= r_cpha ? w_rx_next : r_rx;
                            r_rx_valid <= 1'b1;
                            r_busy     <= 1'b0;
                            r_tx_ready <= 1'b1;
                        end else begin
                            r_state <= S_LEAD;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign tx_ready = r_tx_ready;
    assign rx_valid = r_rx_valid;
    assign rx_data  = r_rx_data;
    assign busy     = r_busy;
    assign SCK      = r_sck;
    assign MOSI     = r_mosi;
    assign nSS      = r_ss;

endmodule
`default_nettype wire

// File: tb/tb_spi_stream_master.sv
`default_nettype none
// ============================================================================
//  Module      : tb_spi_stream_master
//  Description : Self-checking bench for spi_stream_master (MSB and LSB builds).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_spi_stream_master;

    typedef struct {
        logic       cp;
        logic       ch;
        logic [3:0] dv;
        logic [1:0] ss;
        logic [7:0] d;
        logic [7:0] s0;
        logic [7:0] s1;
        logic       lp;
        logic       same;
        logic [7:0] erx;
        int         elat;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, cfg_wr, cfg_cpol, cfg_cpha, tx_valid;
    logic [1:0] cfg_ss;
    logic [3:0] cfg_div;
    logic [7:0] tx_data;

    logic       tx_ready_m, rx_valid_m, busy_m, sck_m, mosi_m;
    logic [7:0] rx_data_m;
    logic [1:0] nss_m, miso_m;
    logic       tx_ready_l, rx_valid_l, busy_l, sck_l, mosi_l;
    logic [7:0] rx_data_l;
    logic [1:0] nss_l, miso_l;

    int checks = 0;
    int errors = 0;

    // Slave-side model: returns sw0/sw1 in SPI order, captures MOSI at sample edges
    logic       m_cpol = 1'b0, m_cpha = 1'b0, loop = 1'b0;
    logic [7:0] sw0 = '0, sw1 = '0;
    int         e = 100;
    int         bidx;
    logic       psck = 1'b0, pbusy = 1'b0;
    logic [7:0] cap_m = '0, cap_l = '0;

    spi_stream_master #(.NSS(2), .WIDTH(8), .DIVW(4), .MSB_FIRST(1)) u_msb (
        .CLK(clk), .RST(rst), .cfg_wr(cfg_wr), .cfg_ss(cfg_ss), .cfg_cpol(cfg_cpol),
        .cfg_cpha(cfg_cpha), .cfg_div(cfg_div), .tx_valid(tx_valid), .tx_data(tx_data),
        .tx_ready(tx_ready_m), .rx_valid(rx_valid_m), .rx_data(rx_data_m), .busy(busy_m),
        .SCK(sck_m), .MOSI(mosi_m), .MISO(miso_m), .nSS(nss_m)
    );

    spi_stream_master #(.NSS(2), .WIDTH(8), .DIVW(4), .MSB_FIRST(0)) u_lsb (
        .CLK(clk), .RST(rst), .cfg_wr(cfg_wr), .cfg_ss(cfg_ss), .cfg_cpol(cfg_cpol),
        .cfg_cpha(cfg_cpha), .cfg_div(cfg_div), .tx_valid(tx_valid), .tx_data(tx_data),
        .tx_ready(tx_ready_l), .rx_valid(rx_valid_l), .rx_data(rx_data_l), .busy(busy_l),
        .SCK(sck_l), .MOSI(mosi_l), .MISO(miso_l), .nSS(nss_l)
    );

    function automatic logic sbit(input logic [7:0] w, input int i, input logic lsb);
        if (i < 0 || i > 7) return 1'b0;
        return lsb ? w[i] : w[7-i];
    endfunction

    always_comb begin
        bidx      = m_cpha ? ((e == 0) ? 0 : (e - 1) / 2) : e / 2;
        miso_m[0] = loop ? mosi_m : sbit(sw0, bidx, 1'b0);
        miso_m[1] = sbit(sw1, bidx, 1'b0);
        miso_l[0] = loop ? mosi_l : sbit(sw0, bidx, 1'b1);
        miso_l[1] = sbit(sw1, bidx, 1'b1);
    end

    always @(posedge clk) begin
        #2;
        if (busy_m && !pbusy) begin
            e     = 0;
            cap_m = '0;
            cap_l = '0;
        end else if (sck_m !== psck) begin
            e = e + 1;
            if ((sck_m != m_cpol) == !m_cpha) begin
                cap_m = {cap_m[6:0], mosi_m};
                cap_l = {mosi_l, cap_l[7:1]};
            end
        end
        psck  = sck_m;
        pbusy = busy_m;
    end

    function automatic logic [7:0] model_rx(input vec_t v);
        logic [7:0] r;
        r = '0;
        if (!v.ss[0]) r = r | (v.lp ? v.d : v.s0);
        if (!v.ss[1]) r = r | v.s1;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic do_cfg(input logic cp, input logic ch, input logic [3:0] dv, input logic [1:0] ss);
        cfg_cpol = cp; cfg_cpha = ch; cfg_div = dv; cfg_ss = ss; cfg_wr = 1'b1;
        @(negedge clk);
        cfg_wr = 1'b0;
        chk("cfg_sck", 32'(sck_m), 32'(cp));
        chk("cfg_nss", 32'(nss_m), 32'(ss));
        chk("cfg_nss_lsb", 32'(nss_l), 32'(ss));
    endtask

    task automatic drain();
        tx_valid = 1'b0;
        cfg_wr   = 1'b0;
        for (int i = 0; i < 600 && (busy_m || rx_valid_m); i++) @(negedge clk);
        @(negedge clk);
    endtask

    task automatic xfer(input vec_t v, input string nm);
        int cyc;
        m_cpol = v.cp; m_cpha = v.ch; sw0 = v.s0; sw1 = v.s1; loop = v.lp;
        if (!v.same) begin
            do_cfg(v.cp, v.ch, v.dv, v.ss);
        end else begin
            cfg_cpol = v.cp; cfg_cpha = v.ch; cfg_div = v.dv; cfg_ss = v.ss; cfg_wr = 1'b1;
        end
        tx_data  = v.d;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        cfg_wr   = 1'b0;
        chk({nm, "_busy"}, 32'(busy_m), 32'd1);
        chk({nm, "_txrdy"}, 32'(tx_ready_m), 32'd0);
        cyc = 0;
        while (!rx_valid_m && cyc < v.elat + 40) begin
            @(negedge clk);
            cyc++;
        end
        chk({nm, "_lat"}, 32'(cyc), 32'(v.elat));
        chk({nm, "_rx"}, 32'(rx_data_m), 32'(v.erx));
        chk({nm, "_rx_lsb"}, 32'(rx_data_l), 32'(v.erx));
        chk({nm, "_rxv_lsb"}, 32'(rx_valid_l), 32'd1);
        chk({nm, "_mosi"}, 32'(cap_m), 32'(v.d));
        chk({nm, "_mosi_lsb"}, 32'(cap_l), 32'(v.d));
        chk({nm, "_edges"}, 32'(e), 32'd16);
        chk({nm, "_done_busy"}, 32'(busy_m), 32'd0);
        chk({nm, "_done_rdy"}, 32'(tx_ready_m), 32'd1);
        chk({nm, "_nss"}, 32'(nss_m), 32'(v.ss));
        chk({nm, "_sck"}, 32'(sck_m), 32'(v.cp));
        chk({nm, "_sck_lsb"}, 32'(sck_l), 32'(v.cp));
        @(negedge clk);
        chk({nm, "_pulse"}, 32'(rx_valid_m), 32'd0);
        chk({nm, "_idle_mosi"}, 32'(mosi_m), 32'd1);
        chk({nm, "_idle_mosi_lsb"}, 32'(mosi_l), 32'd1);
        drain();
    endtask

    vec_t tbl[7];
    vec_t rv;

    initial begin
        int cyc;
        int npulse;
        logic seen;

        tbl[0] = '{1'b0, 1'b0, 4'd0,  2'b10, 8'hA5, 8'h00, 8'h00, 1'b1, 1'b0, 8'hA5, 16};
        tbl[1] = '{1'b1, 1'b1, 4'd2,  2'b10, 8'h5A, 8'h3C, 8'hFF, 1'b0, 1'b0, 8'h3C, 48};
        tbl[2] = '{1'b0, 1'b1, 4'd1,  2'b01, 8'h0F, 8'hAA, 8'hC3, 1'b0, 1'b1, 8'hC3, 32};
        tbl[3] = '{1'b1, 1'b0, 4'd0,  2'b00, 8'h96, 8'hF0, 8'h0F, 1'b0, 1'b0, 8'hFF, 16};
        tbl[4] = '{1'b0, 1'b0, 4'd0,  2'b11, 8'hFF, 8'hFF, 8'hFF, 1'b0, 1'b0, 8'h00, 16};
        tbl[5] = '{1'b0, 1'b0, 4'd15, 2'b10, 8'h7E, 8'h81, 8'h00, 1'b0, 1'b1, 8'h81, 256};
        tbl[6] = '{1'b1, 1'b1, 4'd0,  2'b00, 8'hC4, 8'h00, 8'h21, 1'b1, 1'b0, 8'hE5, 16};

        rst = 1'b1; cfg_wr = 1'b0; cfg_cpol = 1'b0; cfg_cpha = 1'b0; cfg_ss = 2'b11;
        cfg_div = '0; tx_valid = 1'b0; tx_data = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_sck", 32'(sck_m), 32'd0);
        chk("rst_mosi", 32'(mosi_m), 32'd1);
        chk("rst_nss", 32'(nss_m), 32'h3);
        chk("rst_busy", 32'(busy_m), 32'd0);
        chk("rst_txrdy", 32'(tx_ready_m), 32'd1);
        chk("rst_rxv", 32'(rx_valid_m), 32'd0);
        chk("rst_rxdata", 32'(rx_data_m), 32'd0);

        for (int i = 0; i < 7; i++) xfer(tbl[i], $sformatf("vec%0d", i));

        // Back-to-back streaming with tx_valid held high
        m_cpol = 1'b0; m_cpha = 1'b0; loop = 1'b1; sw0 = '0; sw1 = '0;
        do_cfg(1'b0, 1'b0, 4'd0, 2'b10);
        tx_data = 8'h01; tx_valid = 1'b1;
        @(negedge clk);
        tx_data = 8'h80;
        cyc = 0; npulse = 0;
        while (cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (rx_valid_m) begin
                if (npulse == 0) begin
                    chk("b2b_lat0", 32'(cyc), 32'd16);
                    chk("b2b_rx0", 32'(rx_data_m), 32'h01);
                end else begin
                    chk("b2b_lat1", 32'(cyc), 32'd33);
                    chk("b2b_rx1", 32'(rx_data_m), 32'h80);
                    chk("b2b_mosi1", 32'(cap_m), 32'h80);
                end
                npulse++;
            end
            if (npulse == 1 && busy_m) tx_valid = 1'b0;
        end
        chk("b2b_pulses", 32'(npulse), 32'd2);
        drain();

        // Config write while busy is dropped; a write in the DONE cycle is taken
        loop = 1'b1;
        do_cfg(1'b0, 1'b0, 4'd0, 2'b10);
        tx_data = 8'h3C; tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        cyc = 0;
        while (!rx_valid_m && cyc < 100) begin
            if (cyc == 3) begin
                cfg_ss = 2'b01; cfg_div = 4'd7; cfg_cpol = 1'b1; cfg_cpha = 1'b1; cfg_wr = 1'b1;
            end else begin
                cfg_wr = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        cfg_wr = 1'b0;
        chk("bsycfg_lat", 32'(cyc), 32'd16);
        chk("bsycfg_nss", 32'(nss_m), 32'h2);
        chk("bsycfg_sck", 32'(sck_m), 32'd0);
        chk("bsycfg_rx", 32'(rx_data_m), 32'h3C);
        do_cfg(1'b0, 1'b0, 4'd0, 2'b01);
        drain();

        // Reset in the middle of a mode-3 word
        m_cpol = 1'b1; m_cpha = 1'b1; loop = 1'b0; sw0 = 8'h99;
        do_cfg(1'b1, 1'b1, 4'd2, 2'b10);
        tx_data = 8'h55; tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mrst_sck", 32'(sck_m), 32'd0);
        chk("mrst_sck_lsb", 32'(sck_l), 32'd0);
        chk("mrst_mosi", 32'(mosi_m), 32'd1);
        chk("mrst_nss", 32'(nss_m), 32'h3);
        chk("mrst_busy", 32'(busy_m), 32'd0);
        chk("mrst_busy_lsb", 32'(busy_l), 32'd0);
        chk("mrst_txrdy", 32'(tx_ready_m), 32'd1);
        chk("mrst_txrdy_lsb", 32'(tx_ready_l), 32'd1);
        chk("mrst_rxdata", 32'(rx_data_m), 32'd0);
        seen = 1'b0;
        repeat (60) begin
            @(negedge clk);
            if (rx_valid_m || rx_valid_l) seen = 1'b1;
        end
        chk("mrst_no_rxv", 32'(seen), 32'd0);

        // Randomised words against the slave-side reference model
        for (int i = 0; i < 24; i++) begin
            rv.cp   = 1'($urandom_range(0, 1));
            rv.ch   = 1'($urandom_range(0, 1));
            rv.dv   = 4'($urandom_range(0, 3));
            rv.ss   = 2'($urandom_range(0, 3));
            rv.d    = 8'($urandom);
            rv.s0   = 8'($urandom);
            rv.s1   = 8'($urandom);
            rv.lp   = 1'($urandom_range(0, 1));
            rv.same = 1'($urandom_range(0, 1));
            rv.erx  = model_rx(rv);
            rv.elat = 16 * (int'(rv.dv) + 1);
            xfer(rv, $sformatf("rnd%0d", i));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, checks %0d errors %0d", checks, errors);
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/spi_stream_master.md
Name: spi_stream_master

Overview:
- Hardware SPI shifter for the extension CPLD. Replaces the bit-banged SCLK/MOSI ctrl-code path: software loads a byte and the block clocks the whole byte out itself.
- Parametrised in slave-select count, word width, bit order and clock divider width.
- Supports all four SPI modes (CPOL/CPHA) and back-to-back streaming with a valid/ready handshake.
- Sits between the ctrl-code decoder (config and tx writes) and the GBUS read mux (rx data and status).

Parameters:
NSS, 2, number of active-low slave selects, 1..4
WIDTH, 8, bits per transfer, 4..16
DIVW, 4, width of the SCK half-period divider field
MSB_FIRST, 1, 1 = MSB shifted first, 0 = LSB first

Ports:
CLK  in  1  system clock; all state on rising edge
RST  in  1  synchronous, active-high reset
cfg_wr  in  1  config load strobe
cfg_ss  in  NSS  requested nSS pattern (active low)
cfg_cpol  in  1  SCK idle level
cfg_cpha  in  1  0 = sample on leading edge, 1 = sample on trailing edge
cfg_div  in  DIVW  SCK half-period = cfg_div+1 CLK cycles
tx_valid  in  1  tx word offered
tx_data  in  WIDTH  word to transmit
tx_ready  out  1  block can accept a word
rx_valid  out  1  one-cycle pulse: rx_data updated
rx_data  out  WIDTH  last received word, held until the next rx_valid
busy  out  1  transfer in progress
SCK  out  1  SPI clock
MOSI  out  1  SPI data out
MISO  in  NSS  per-slave data in
nSS  out  NSS  slave selects, active low

Behaviour:
- Reset values:
  - SCK=0, MOSI=1, nSS=all ones, cpol=cpha=0, div=0.
  - rx_data=0, rx_valid=0, busy=0, tx_ready=1.
  - State=IDLE. An active transfer is aborted without an rx_valid pulse.
- Config register:
  - cfg_wr is accepted only when busy=0. It loads nSS, cpol, cpha and div, and SCK takes the new cpol on the next cycle.
  - cfg_wr while busy=1 is dropped entirely and has no side effect.
  - nSS is purely software-driven; the block never toggles it itself.
- States: IDLE, LEAD, TRAIL, DONE.
  - IDLE: tx_ready=1. tx_valid&&tx_ready at edge 0 loads the shift register and bit counter (WIDTH). busy=1 and tx_ready=0 from edge 0. Go to LEAD.
  - LEAD: wait H=div+1 cycles, then toggle SCK to the active level (!cpol). Go to TRAIL.
  - TRAIL: wait H cycles, then return SCK to cpol and decrement the counter. If counter=0 go to DONE, else go to LEAD.
  - DONE (one cycle): rx_data <= shift register, rx_valid=1, busy=0, tx_ready=1. Next state is IDLE.
  - A tx_valid accepted during DONE starts the next word immediately (LEAD) with no idle cycle.
- Bit timing:
  - cpha=0: first bit is on MOSI from edge 0. Sample on each leading edge; shift out the next bit on each trailing edge, except after the last bit.
  - cpha=1: shift out a bit on each leading edge; sample on each trailing edge.
  - MOSI holds the last bit after completion, and returns to 1 in IDLE.
- Latency: rx_valid is high in the cycle that begins 2*WIDTH*H clocks after the accept edge. Streaming throughput is one word per 2*WIDTH*H+1 cycles.
- Sampled MISO = OR over i of (MISO[i] & !nSS[i]). With no slave selected the transfer still runs and received bits are 0.
- Bit order:
  - MSB_FIRST=1: shift out bit WIDTH-1 first; received bits enter at bit 0.
  - MSB_FIRST=0: mirror of the above.
- Divider counter wraps to 0 at every SCK edge; div is latched at the accept edge, not read live.
- Simultaneous events:
  - RST beats everything.
  - cfg_wr in the DONE cycle is accepted, because busy=0.
  - cfg_wr together with tx_valid in IDLE: config is applied first, and the transfer uses the new cpol/cpha/div.

Test Plan:
- Reset mid-transfer: assert RST for 1 cycle at cycle 5 of a word. Required after reset: SCK=0, MOSI=1, nSS=all ones, busy=0, tx_ready=1, and no rx_valid pulse ever appears.
- Mode 0, div=0, WIDTH=8, nSS=2'b10, MISO[0]=MOSI loopback, send 0xA5. Required: exactly 8 SCK rising edges; rx_valid at cycle 16 after the accept edge; rx_data=0xA5.
- Mode 3 (cpol=1, cpha=1), div=2, MISO[0] driven by a slave model returning 0x3C. Required: SCK idles high; rx_data=0x3C at cycle 48; bit order checked against an MSB_FIRST=0 build returning 0x3C on reversed wire order.
- Back-to-back: tx_valid held high with 0x01 then 0x80, div=0. Required: rx_valid pulses at cycles 16 and 33; SCK has no idle gap beyond the single DONE cycle.
- Config write during busy: cfg_wr with nSS=2'b01 and div=7 while busy. Required: nSS and SCK period unchanged; the next cfg_wr after rx_valid is applied.
- No slave selected (nSS=2'b11), MISO all ones: send 0xFF. Required: rx_data=0x00, busy=0 at cycle 16.
